// File: rtl/shifter_readout_ctrl.sv
// shifter_readout_ctrl: snapshots four 12-bit error counters and shifts them out as a framed serial stream
module shifter_readout_ctrl #(
    parameter logic [7:0] SYNC_WORD  = 8'hA5,
    parameter int         GAP_CYCLES = 4
) (
    input  logic        i_data_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [11:0] i_shift_error_0_0,
    input  logic [11:0] i_shift_error_0_1,
    input  logic [11:0] i_shift_error_1_0,
    input  logic [11:0] i_shift_error_1_1,
    output logic        o_save_data,
    output logic        o_data_out,
    output logic        o_frame,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_seq
);
    typedef enum logic [2:0] {S_IDLE, S_SNAP, S_SYNC, S_SEQN, S_DATA, S_PAR, S_GAP} state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_bit_cnt, w_bit_nxt;
    logic [7:0]  r_gap_cnt, w_gap_nxt;
    logic [11:0] r_sh_00, r_sh_01, r_sh_10, r_sh_11;
    logic [3:0]  r_seq;
    logic        r_data_out, r_frame;
    logic        w_data_nxt, w_frame_nxt, w_done;
    logic [47:0] w_data_vec;

    assign w_data_vec  = {r_sh_11, r_sh_10, r_sh_01, r_sh_00};
    assign w_done      = (r_state == S_GAP) && (r_gap_cnt == GAP_LAST) && !i_abort;
    assign w_frame_nxt = (w_state_nxt == S_SYNC) || (w_state_nxt == S_SEQN) ||
                         (w_state_nxt == S_DATA) || (w_state_nxt == S_PAR);

    assign o_save_data = (r_state == S_SNAP);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = w_done;
    assign o_data_out  = r_data_out;
    assign o_frame     = r_frame;
    assign o_seq       = r_seq;

    // Next-state and bit/gap counter sequencing; abort overrides everything outside IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = S_SNAP;
            S_SNAP: begin
                w_state_nxt = S_SYNC;
                w_bit_nxt   = '0;
            end
            S_SYNC: begin
                w_state_nxt = (r_bit_cnt == 6'd7) ? S_SEQN : S_SYNC;
                w_bit_nxt   = (r_bit_cnt == 6'd7) ? 6'd0 : r_bit_cnt + 6'd1;
            end
            S_SEQN: begin
                w_state_nxt = (r_bit_cnt == 6'd3) ? S_DATA : S_SEQN;
                w_bit_nxt   = (r_bit_cnt == 6'd3) ? 6'd0 : r_bit_cnt + 6'd1;
            end
            S_DATA: begin
                w_state_nxt = (r_bit_cnt == 6'd47) ? S_PAR : S_DATA;
                w_bit_nxt   = (r_bit_cnt == 6'd47) ? 6'd0 : r_bit_cnt + 6'd1;
            end
            S_PAR: begin
                w_state_nxt = S_GAP;
                w_gap_nxt   = '0;
            end
            S_GAP: begin
                w_state_nxt = (r_gap_cnt != GAP_LAST) ? S_GAP : (i_start ? S_SNAP : S_IDLE);
                w_gap_nxt   = (r_gap_cnt == GAP_LAST) ? 8'd0 : r_gap_cnt + 8'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = '0;
            w_gap_nxt   = '0;
        end
    end

    // Select the bit DATA_OUT will carry in the next cycle so the output can be registered
    always_comb begin
        w_data_nxt = 1'b0;
        case (w_state_nxt)
            S_SYNC:  w_data_nxt = SYNC_WORD[w_bit_nxt[2:0]];
            S_SEQN:  w_data_nxt = r_seq[w_bit_nxt[1:0]];
            S_DATA:  w_data_nxt = w_data_vec[w_bit_nxt];
            S_PAR:   w_data_nxt = ^w_data_vec;
            default: w_data_nxt = 1'b0;
        endcase
    end

    // State, counters and registered serial outputs
    always_ff @(posedge i_data_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_data_out <= 1'b0;
            r_frame    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_data_out <= w_data_nxt;
            r_frame    <= w_frame_nxt;
        end
    end

    // Shadow copy of the live counters taken on the edge that ends SNAP
    always_ff @(posedge i_data_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_00 <= '0;
            r_sh_01 <= '0;
            r_sh_10 <= '0;
            r_sh_11 <= '0;
        end else if (r_state == S_SNAP) begin
            r_sh_00 <= i_shift_error_0_0;
            r_sh_01 <= i_shift_error_0_1;
            r_sh_10 <= i_shift_error_1_0;
            r_sh_11 <= i_shift_error_1_1;
        end
    end

    // Frame sequence number advances only when a frame and its gap complete
    always_ff @(posedge i_data_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_seq <= '0;
        else if (w_done) r_seq <= r_seq + 4'd1;
    end
endmodule

// File: tb/tb_shifter_readout_ctrl.sv
// tb_shifter_readout_ctrl: scoreboard bench for the serial error-count readout framer
module tb_shifter_readout_ctrl;
    localparam int         GAP  = 4;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0;
    logic [11:0] e00 = '0, e01 = '0, e10 = '0, e11 = '0;
    logic        save_data, data_out, frame, busy, done;
    logic [3:0]  seq;
    int          n_total = 0, n_bad = 0, n_done = 0, last_len = 0, cap_len = 0;
    logic [60:0] cap = '0;
    logic [60:0] exp_q[$], got_q[$];
    logic [3:0]  exp_seq = '0;
    logic [60:0] lit;
    int          d0, k, g, idle;

    always #5 clk = ~clk;

    shifter_readout_ctrl #(.SYNC_WORD(SYNC), .GAP_CYCLES(GAP)) dut (
        .i_data_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_shift_error_0_0(e00), .i_shift_error_0_1(e01),
        .i_shift_error_1_0(e10), .i_shift_error_1_1(e11),
        .o_save_data(save_data), .o_data_out(data_out), .o_frame(frame),
        .o_busy(busy), .o_done(done), .o_seq(seq)
    );

    // Monitor: count DONE pulses and assemble each FRAME burst; only full 61-bit frames go to the scoreboard
    always @(negedge clk) begin
        if (done) n_done <= n_done + 1;
        if (frame) begin
            if (cap_len < 61) cap[cap_len] <= data_out;
            cap_len <= cap_len + 1;
        end else if (cap_len != 0) begin
            last_len <= cap_len;
            if (cap_len == 61) got_q.push_back(cap);
            cap_len <= 0;
        end
    end

    function automatic logic [60:0] make_frame(input logic [3:0] s, input logic [11:0] a, b, c, d);
        logic [47:0] dv;
        dv = {d, c, b, a};
        return {^dv, dv, s, SYNC};
    endfunction

    function automatic logic sig(input int which);
        return (which == 0) ? save_data : (which == 1) ? frame : done;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_for(input int which, input logic lvl, input string tag);
        int n;
        n = 0;
        while (sig(which) !== lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sig(which), lvl);
    endtask

    task automatic wait_done_lat(input string tag, input int exp_k);
        int n;
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, exp_k);
    endtask

    task automatic start_frame(input logic [11:0] a, b, c, d, input logic ab, input logic keep);
        e00 = a; e01 = b; e10 = c; e11 = d;
        start = 1'b1;
        abort = ab;
        if (keep) exp_q.push_back(make_frame(exp_seq, a, b, c, d));
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_frames(input string tag);
        logic [60:0] f;
        while (got_q.size() > 0) begin
            f = got_q.pop_front();
            if (exp_q.size() == 0) chk({tag, "_unexpected"}, f, '0);
            else chk(tag, f, exp_q.pop_front());
        end
    endtask

    task automatic rand_inputs();
        e00 = 12'($urandom); e01 = 12'($urandom);
        e10 = 12'($urandom); e11 = 12'($urandom);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_frame", frame, 0); chk("rst_dout", data_out, 0);
        chk("rst_save", save_data, 0); chk("rst_done", done, 0); chk("rst_seq", seq, 0);
        rst_n = 1'b1;
        @(negedge clk);

        start_frame(12'h001, 12'h003, 12'h000, 12'hFFF, 1'b0, 1'b1);
        chk("snap_save", save_data, 1); chk("snap_busy", busy, 1); chk("snap_frame", frame, 0);
        @(negedge clk);
        chk("sync0_save", save_data, 0); chk("sync0_frame", frame, 1); chk("sync0_bit", data_out, 1);
        wait_done_lat("single_done_lat", 60 + GAP);
        #1 chk("single_done_cnt", n_done, 1);
        exp_seq++;
        @(negedge clk);
        chk("single_seq", seq, exp_seq); chk("single_idle", busy, 0); chk("single_done_low", done, 0);
        #1 chk("single_done_once", n_done, 1);
        chk("single_frame_cnt", got_q.size(), 1);
        lit = {1'b1, 48'hFFF000003001, 4'h0, 8'hA5};
        if (got_q.size() > 0) chk("single_literal", got_q[0], lit);
        check_frames("single_frame");

        @(negedge clk);
        start_frame(12'h5A3, 12'h0C7, 12'hE18, 12'h2B4, 1'b0, 1'b1);
        k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            rand_inputs();
            start = k[0];
            k++;
        end
        start = 1'b0;
        chk("hold_done_lat", k, 61 + GAP);
        exp_seq++;
        @(negedge clk);
        chk("hold_seq", seq, exp_seq);
        check_frames("hold_frame");

        start_frame(12'h123, 12'h456, 12'h789, 12'hABC, 1'b0, 1'b0);
        repeat (33) @(negedge clk);
        chk("abort_pre_frame", frame, 1);
        d0 = n_done;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0); chk("abort_frame", frame, 0);
        chk("abort_dout", data_out, 0); chk("abort_seq", seq, exp_seq);
        #1 chk("abort_len", last_len, 33);
        repeat (10) @(negedge clk);
        chk("abort_no_done", n_done, d0); chk("abort_stay_idle", busy, 0);
        start_frame(12'h321, 12'h654, 12'h987, 12'hCBA, 1'b0, 1'b1);
        wait_done_lat("post_abort_lat", 61 + GAP);
        exp_seq++;
        @(negedge clk);
        chk("post_abort_seq", seq, exp_seq);
        check_frames("post_abort_frame");

        start_frame(12'h0F0, 12'hF0F, 12'h555, 12'hAAA, 1'b1, 1'b1);
        chk("both_idle_snap", save_data, 1);
        wait_done_lat("both_idle_lat", 61 + GAP);
        exp_seq++;
        @(negedge clk);
        chk("both_idle_seq", seq, exp_seq);
        check_frames("both_idle_frame");

        start_frame(12'h111, 12'h222, 12'h333, 12'h444, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        chk("both_data_pre", frame, 1);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("both_data_busy", busy, 0); chk("both_data_frame", frame, 0); chk("both_data_seq", seq, exp_seq);

        start_frame(12'h777, 12'h888, 12'h999, 12'h000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_rst_frame", frame, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0); chk("arst_frame", frame, 0); chk("arst_dout", data_out, 0);
        chk("arst_save", save_data, 0); chk("arst_done", done, 0); chk("arst_seq", seq, 0);
        @(negedge clk);
        chk("arst_hold_busy", busy, 0);
        rst_n = 1'b1;
        exp_seq = '0;
        @(negedge clk);
        start_frame(12'hBEE, 12'hCAF, 12'h00D, 12'hF00, 1'b0, 1'b1);
        wait_done_lat("recov_lat", 61 + GAP);
        exp_seq++;
        @(negedge clk);
        chk("recov_seq", seq, exp_seq);
        check_frames("recov_frame");

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_seq = '0;
        @(negedge clk);
        rand_inputs();
        start = 1'b1;
        for (int i = 0; i < 17; i++) exp_q.push_back(make_frame(4'(i), e00, e01, e10, e11));
        d0 = n_done;
        for (int i = 0; i < 17; i++) begin
            wait_for(0, 1'b1, "b2b_snap");
            if (i == 16) start = 1'b0;
            wait_for(1, 1'b1, "b2b_frame_on");
            wait_for(1, 1'b0, "b2b_frame_off");
            if (i < 16) begin
                g = 0;
                idle = 0;
                while (!save_data && g < 300) begin
                    if (!busy) idle++;
                    g++;
                    @(negedge clk);
                end
                chk("b2b_gap", g, GAP);
                chk("b2b_no_idle", idle, 0);
            end
        end
        wait_done_lat("b2b_last_lat", GAP - 1);
        #1 chk("b2b_done_cnt", n_done - d0, 17);
        @(negedge clk);
        chk("b2b_seq_wrap", seq, 1); chk("b2b_idle_end", busy, 0);
        check_frames("b2b_frame");

        chk("exp_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/shifter_readout_ctrl.md
SHIFTER_READOUT_CTRL -- requirements
Module: shifter_readout_ctrl

Interface
REQ-001 Parameter SYNC_WORD, default 8'hA5: frame header, sent LSB first.
REQ-002 Parameter GAP_CYCLES, default 4 (legal 1..255): idle cycles after each frame.
REQ-003 DATA_CLK  in  1: sole clock; all state updates on its rising edge.
REQ-004 RST  in  1: reset, asynchronous and active-low.
REQ-005 START  in  1: level request for a readout frame; sampled in IDLE and at the end of GAP.
REQ-006 ABORT  in  1: synchronous frame cancel.
REQ-007 SHIFT_ERROR_0_0 / _0_1 / _1_0 / _1_1  in  12 each: live per-chain error counts.
REQ-008 SAVE_DATA  out  1: one-cycle snapshot strobe to the error-count capture logic.
REQ-009 DATA_OUT  out  1: serial frame bit, registered.
REQ-010 FRAME  out  1: high while DATA_OUT carries a valid frame bit.
REQ-011 BUSY  out  1: high in every state except IDLE.
REQ-012 DONE  out  1: one-cycle pulse when a frame and its gap complete.
REQ-013 SEQ  out  4: current frame sequence number.

Function
REQ-014 The FSM SHALL have the states IDLE, SNAP, SYNC(8), SEQN(4), DATA(48), PAR(1) and GAP(GAP_CYCLES); the number in brackets is the cycle count spent in that state.
REQ-015 IDLE: if START=1 at a clock edge, the FSM SHALL enter SNAP on that edge; otherwise it stays in IDLE.
REQ-016 SNAP: SAVE_DATA=1 for exactly this cycle.
  - On the edge leaving SNAP, the block SHALL copy all four SHIFT_ERROR inputs into internal 12-bit shadow registers.
  - The FSM then enters SYNC.
REQ-017 SYNC: DATA_OUT SHALL send SYNC_WORD[0..7], one bit per cycle.
REQ-018 SEQN: DATA_OUT SHALL send SEQ[0..3].
REQ-019 DATA: DATA_OUT SHALL send the shadow registers in the order 0_0, 0_1, 1_0, 1_1, 12 bits each, LSB first.
  - Bit index and chain index come from a 6-bit counter that runs 0..47.
REQ-020 PAR: DATA_OUT SHALL be the even-parity bit over the 48 data bits, i.e. the XOR of all 48 bits.
REQ-021 FRAME SHALL be 1 in SYNC, SEQN, DATA and PAR, and 0 otherwise; a frame is exactly 61 bits.
REQ-022 Outside FRAME, DATA_OUT SHALL be 0.
REQ-023 GAP: after GAP_CYCLES cycles the block SHALL do three things on the same final cycle:
  - pulse DONE;
  - increment SEQ modulo 16 (15 wraps to 0);
  - go to SNAP if START=1, else to IDLE, so back-to-back frames have no extra idle cycle.
REQ-024 Latency: START is sampled high at edge n in IDLE.
  - SAVE_DATA is high in cycle n+1.
  - The first SYNC bit appears in cycle n+2.
  - DONE pulses in cycle n+62+GAP_CYCLES.
REQ-025 START changes during SNAP through PAR SHALL be ignored; the frame always completes unless aborted.
REQ-026 Input changes after the SNAP edge SHALL NOT alter the frame in progress.
REQ-027 ABORT=1 in any non-IDLE state SHALL send the FSM to IDLE on the next edge, with these outputs:
  - FRAME=0 and DATA_OUT=0;
  - no DONE pulse;
  - SEQ unchanged.
REQ-028 ABORT takes priority over START when both are high; ABORT in IDLE SHALL have no effect.

Reset
REQ-029 While RST=0, and asynchronously on its assertion:
  - the FSM SHALL be IDLE;
  - SAVE_DATA, DATA_OUT, FRAME, BUSY and DONE SHALL be 0;
  - SEQ SHALL be 0;
  - the bit counters and shadow registers SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame immediately, with no DONE pulse.
REQ-031 After RST deasserts, the first frame SHALL carry SEQ=0.

Verification
REQ-032 Single frame.
  - Stimulus: inputs 0_0=12'h001, 0_1=12'h003, 1_0=12'h000, 1_1=12'hFFF, START pulsed for one cycle.
  - Response: SAVE_DATA for one cycle; DATA_OUT 1,0,1,0,0,1,0,1 then 0,0,0,0; data bits 1,then 11 zeros,1,1,then 10 zeros,12 zeros,12 ones; parity 1; DONE once; SEQ becomes 1.
REQ-033 START held high for 17 frames.
  - Response: SEQ counts 0..15 and wraps to 0.
  - Exactly GAP_CYCLES zero cycles between frames and no IDLE cycle.
REQ-034 Inputs changed every cycle after SNAP.
  - Response: the frame data equals the values present at the SNAP edge.
REQ-035 ABORT asserted at data bit 20.
  - Response: next cycle IDLE, FRAME=0, no DONE, SEQ unchanged.
  - A following START produces a full 61-bit frame.
REQ-036 RST pulsed low mid-SYNC.
  - Response: all outputs 0 immediately, SEQ=0.
  - Recovery frame is correct with SEQ=0.
REQ-037 START and ABORT high together in IDLE.
  - Response: enters SNAP.
  - Both high in DATA: aborts to IDLE.
